// File: rtl/div_if.sv
// EX-stage <-> divider handshake bundle: operands and control in, stall and HI/LO result out.
interface div_if;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        stall_req;
  logic        busy;
  logic        result_valid;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, signed_div, dividend, divisor, cancel,
    input  stall_req, busy, result_valid, hi, lo
  );

  modport slave (
    input  start, signed_div, dividend, divisor, cancel,
    output stall_req, busy, result_valid, hi, lo
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle 32-bit restoring divider (DIV/DIVU) for the EX stage; quotient -> lo, remainder -> hi.
// Define DIV_ZERO_FAST_EN to complete a divide-by-zero in 2 cycles instead of 33.
module div_seq (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ZERO = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [31:0] rem, quo, dvs, dvd_raw;
  logic [5:0]  cnt;
  logic        neg_q, neg_r, dvs_zero;
  logic [31:0] hi_r, lo_r;

  logic        accept;
  logic        finish;
  logic [32:0] rem_sh, diff;
  logic [31:0] rem_nxt, quo_nxt;
  logic [31:0] fin_hi, fin_lo;
  logic [31:0] dvd_mag, dvs_mag;

  assign accept = bus.start & ~bus.cancel & ((state == S_IDLE) | (state == S_DONE));
  assign finish = ~bus.cancel & (((state == S_RUN) & (cnt == 6'd31)) | (state == S_ZERO));

  assign dvd_mag = (bus.signed_div & bus.dividend[31]) ? (~bus.dividend + 32'd1) : bus.dividend;
  assign dvs_mag = (bus.signed_div & bus.divisor[31])  ? (~bus.divisor  + 32'd1) : bus.divisor;

  // One restoring step: shift the next dividend bit into the remainder and trial-subtract.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    rem_sh  = {rem, quo[31]};
    diff    = rem_sh - {1'b0, dvs};
    rem_nxt = rem_sh[31:0];
    quo_nxt = {quo[30:0], 1'b0};
    if (!diff[32]) begin
      rem_nxt = diff[31:0];
      quo_nxt = {quo[30:0], 1'b1};
    end
  end

  // Divide-by-zero reports the raw dividend, bypassing the sign fix-up.
  always_comb begin
    fin_lo = neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
    fin_hi = neg_r ? (~rem_nxt + 32'd1) : rem_nxt;
    if (dvs_zero) begin
      fin_lo = 32'hFFFF_FFFF;
      fin_hi = dvd_raw;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          state_nxt = (bus.divisor == 32'd0) ? S_ZERO : S_RUN;
`else
          state_nxt = S_RUN;
`endif
        end
      end
      S_RUN:   if (cnt == 6'd31) state_nxt = S_DONE;
      S_ZERO:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.cancel) state_nxt = S_IDLE;
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, so hi/lo read zero straight out of reset.
      state    <= S_IDLE;
      rem      <= 32'd0;
      quo      <= 32'd0;
      dvs      <= 32'd0;
      dvd_raw  <= 32'd0;
      cnt      <= 6'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dvs_zero <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rem      <= 32'd0;
        quo      <= dvd_mag;
        dvs      <= dvs_mag;
        dvd_raw  <= bus.dividend;
        cnt      <= 6'd0;
        neg_q    <= bus.signed_div & (bus.dividend[31] ^ bus.divisor[31]);
        neg_r    <= bus.signed_div & bus.dividend[31];
        dvs_zero <= (bus.divisor == 32'd0);
      end else if ((state == S_RUN) && !bus.cancel) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + 6'd1;
      end
      if (finish) begin
        hi_r <= fin_hi;
        lo_r <= fin_lo;
      end
    end
  end

  assign bus.busy         = (state == S_RUN) | (state == S_ZERO);
  assign bus.stall_req    = accept | (state == S_RUN) | (state == S_ZERO);
  assign bus.result_valid = (state == S_DONE);
  assign bus.hi           = hi_r;
  assign bus.lo           = lo_r;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: randomized DIV/DIVU against a plain-arithmetic reference model.
module tb_div_seq;

  logic clk;
  logic rst;
  div_if bus ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: 64-bit integer division truncating toward zero, truncated back to 32 bits.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 32'd0) ? 1 : 32;
`else
    return (b == 32'd0) ? 32 : 32;
`endif
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every result_valid must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (!rst && bus.result_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_result_valid", bus.result_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("lo", bus.lo, e.lo);
        check("hi", bus.hi, e.hi);
        check("latency", cyc, e.cyc);
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
  end

  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b, input bit expect_result);
    logic [63:0] m;
    bus.start      = 1'b1;
    bus.signed_div = s;
    bus.dividend   = a;
    bus.divisor    = b;
    #1 check("stall_rise", bus.stall_req, 1'b1);
    @(posedge clk);
    #1;
    if (expect_result) begin
      m = model(s, a, b);
      sb_q.push_back('{hi: m[63:32], lo: m[31:0], cyc: cyc + latency(b)});
    end
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(output bit stall_ok);
    stall_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.result_valid) return;
      if (!bus.stall_req) stall_ok = 1'b0;
    end
    check("timeout_result_valid", bus.result_valid, 1'b1);
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    start_op(s, a, b, 1'b1);
    wait_valid(ok);
    check("stall_hold", ok, 1'b1);
    check("stall_done", bus.stall_req, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd0;
    bus.divisor    = 32'd0;
    bus.cancel     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_stall", bus.stall_req, 1'b0);
    check("rst_valid", bus.result_valid, 1'b0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(1'b0, 32'd100, 32'd7);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 32'h1234_5678, 32'd0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd0);

    // Cancel mid-run: no result, hi/lo keep the last completion.
    start_op(1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check("cancel_pre_busy", bus.busy, 1'b1);
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    check("cancel_busy", bus.busy, 1'b0);
    check("cancel_stall", bus.stall_req, 1'b0);
    check("cancel_hilo", {bus.hi, bus.lo}, {last_hi, last_lo});
    repeat (40) @(posedge clk);
    #1;

    // Cancel wins over a simultaneous start.
    bus.start    = 1'b1;
    bus.cancel   = 1'b1;
    bus.dividend = 32'd55;
    bus.divisor  = 32'd5;
    #1 check("cancel_start_stall", bus.stall_req, 1'b0);
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("cancel_start_busy", bus.busy, 1'b0);
    repeat (40) @(posedge clk);
    #1;

    // Back-to-back: second start presented in the DONE cycle.
    start_op(1'b0, 32'd50, 32'd5, 1'b1);
    wait_valid(ok);
    check("b2b_stall_hold1", ok, 1'b1);
    start_op(1'b0, 32'd9, 32'd4, 1'b1);
    wait_valid(ok);
    check("b2b_stall_hold2", ok, 1'b1);
    check("b2b_stall_done", bus.stall_req, 1'b0);
    @(posedge clk);
    #1;

    // Reset mid-operation.
    start_op(1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_stall", bus.stall_req, 1'b0);
    check("midrst_valid", bus.result_valid, 1'b0);
    check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    last_hi = 32'd0;
    last_lo = 32'd0;
    @(posedge clk);
    #1;
    run_op(1'b0, 32'd77, 32'd5);

    // Randomized traffic, occasionally chaining the next start into the DONE cycle.
    for (int n = 0; n < 150; n++) begin
      logic        s;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = rand_word();
      b = rand_word();
      start_op(s, a, b, 1'b1);
      wait_valid(ok);
      check("rand_stall_hold", ok, 1'b1);
      check("rand_stall_done", bus.stall_req, 1'b0);
      if ($urandom_range(0, 3) != 0) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (40) @(posedge clk);
    #1;

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
